// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the accumulator CPU control sequencer: micro-states,
// opcodes, the strobe word, and the per-opcode execute length.
package cpu_ctrl_pkg;

   localparam int OPC_W = 4;

   typedef enum logic [2:0] {
      FETCH_ADDR  = 3'd0,
      FETCH_INSTR = 3'd1,
      EXEC1       = 3'd2,
      EXEC2       = 3'd3,
      EXEC3       = 3'd4,
      HALT        = 3'd5
   } state_t;

   localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
   localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
   localparam logic [OPC_W-1:0] OP_STA = 4'h4;
   localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
   localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
   localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
   localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
   localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

   typedef struct packed {
      logic pc_out;
      logic pc_inc;
      logic pc_load;
      logic mar_in;
      logic ram_out;
      logic ram_in;
      logic ir_in;
      logic ir_out;
      logic a_in;
      logic a_out;
      logic b_in;
      logic alu_out;
      logic alu_opcode;
      logic alu_bus_wr_en;
      logic out_in;
      logic halted;
   } ctrl_word_t;

   // Idle word: no strobes, ALU left selecting ADD.
   function automatic ctrl_word_t ctrl_idle();
      ctrl_word_t cw;
      cw            = '0;
      cw.alu_opcode = 1'b1;
      return cw;
   endfunction

   // Number of EXEC states an opcode occupies (0 = fetch only).
   function automatic logic [1:0] exec_steps(input logic [OPC_W-1:0] op);
      case (op)
         OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT: return 2'd1;
         OP_LDA, OP_STA:                       return 2'd2;
         OP_ADD, OP_SUB:                       return 2'd3;
         default:                              return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of micro-state, opcode and ALU flags into the
// one-hot bus/load control word.
module alu_ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t           state_i,
   input  logic [OPC_W-1:0] opcode_i,
   input  logic             carry_i,
   input  logic             zero_i,
   output ctrl_word_t       cw_o
);

   always_comb begin
      cw_o = ctrl_idle();
      case (state_i)
         FETCH_ADDR: begin
            cw_o.pc_out = 1'b1;
            cw_o.mar_in = 1'b1;
         end
         FETCH_INSTR: begin
            cw_o.ram_out = 1'b1;
            cw_o.ir_in   = 1'b1;
            cw_o.pc_inc  = 1'b1;
         end
         EXEC1: begin
            case (opcode_i)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  cw_o.ir_out = 1'b1;
                  cw_o.mar_in = 1'b1;
               end
               OP_LDI: begin
                  cw_o.ir_out = 1'b1;
                  cw_o.a_in   = 1'b1;
               end
               OP_JMP: begin
                  cw_o.ir_out  = 1'b1;
                  cw_o.pc_load = 1'b1;
               end
               // Not-taken jumps still put the operand on the bus but load nothing.
               OP_JC: begin
                  cw_o.ir_out  = 1'b1;
                  cw_o.pc_load = carry_i;
               end
               OP_JZ: begin
                  cw_o.ir_out  = 1'b1;
                  cw_o.pc_load = zero_i;
               end
               OP_OUT: begin
                  cw_o.a_out  = 1'b1;
                  cw_o.out_in = 1'b1;
               end
               default: ;
            endcase
         end
         EXEC2: begin
            case (opcode_i)
               OP_LDA: begin
                  cw_o.ram_out = 1'b1;
                  cw_o.a_in    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  cw_o.ram_out = 1'b1;
                  cw_o.b_in    = 1'b1;
               end
               OP_STA: begin
                  cw_o.a_out  = 1'b1;
                  cw_o.ram_in = 1'b1;
               end
               default: ;
            endcase
         end
         EXEC3: begin
            if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               cw_o.alu_out       = 1'b1;
               cw_o.a_in          = 1'b1;
               cw_o.alu_bus_wr_en = 1'b1;
               cw_o.alu_opcode    = (opcode_i != OP_SUB);
            end
         end
         HALT:    cw_o.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_control_sequencer.sv
// Fetch/execute micro-sequencer for the 8-bit accumulator CPU: state
// register and next-state logic; strobes come from alu_ctrl_decode.
module alu_control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int OPCODE_WIDTH = OPC_W
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [OPCODE_WIDTH-1:0] i_opcode,
   input  logic                    i_carry_flag,
   input  logic                    i_zero_flag,
   output logic                    o_pc_out,
   output logic                    o_pc_inc,
   output logic                    o_pc_load,
   output logic                    o_mar_in,
   output logic                    o_ram_out,
   output logic                    o_ram_in,
   output logic                    o_ir_in,
   output logic                    o_ir_out,
   output logic                    o_a_in,
   output logic                    o_a_out,
   output logic                    o_b_in,
   output logic                    o_alu_out,
   output logic                    o_alu_opcode,
   output logic                    o_alu_bus_wr_en,
   output logic                    o_out_in,
   output logic                    o_halted,
   output logic [2:0]              o_state
);

   state_t     state_q, state_d;
   ctrl_word_t cw_dec, cw;
   logic [1:0] steps;

   assign steps = exec_steps(i_opcode);

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_ADDR:  state_d = FETCH_INSTR;
         FETCH_INSTR: begin
            if (i_opcode == OP_HLT)  state_d = HALT;
            else if (steps != 2'd0)  state_d = EXEC1;
            else                     state_d = FETCH_ADDR;
         end
         EXEC1:   state_d = (steps > 2'd1) ? EXEC2 : FETCH_ADDR;
         EXEC2:   state_d = (steps > 2'd2) ? EXEC3 : FETCH_ADDR;
         EXEC3:   state_d = FETCH_ADDR;
         HALT:    state_d = HALT;
         default: state_d = FETCH_ADDR;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= FETCH_ADDR;
      else          state_q <= state_d;
   end

   alu_ctrl_decode u_decode (
      .state_i  (state_q),
      .opcode_i (i_opcode),
      .carry_i  (i_carry_flag),
      .zero_i   (i_zero_flag),
      .cw_o     (cw_dec)
   );

   // While reset is held even the FETCH_ADDR strobes are suppressed.
   assign cw = i_rst_n ? cw_dec : ctrl_idle();

   assign o_pc_out        = cw.pc_out;
   assign o_pc_inc        = cw.pc_inc;
   assign o_pc_load       = cw.pc_load;
   assign o_mar_in        = cw.mar_in;
   assign o_ram_out       = cw.ram_out;
   assign o_ram_in        = cw.ram_in;
   assign o_ir_in         = cw.ir_in;
   assign o_ir_out        = cw.ir_out;
   assign o_a_in          = cw.a_in;
   assign o_a_out         = cw.a_out;
   assign o_b_in          = cw.b_in;
   assign o_alu_out       = cw.alu_out;
   assign o_alu_opcode    = cw.alu_opcode;
   assign o_alu_bus_wr_en = cw.alu_bus_wr_en;
   assign o_out_in        = cw.out_in;
   assign o_halted        = cw.halted;
   assign o_state         = state_q;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: vector table, instruction-level reference
// model under random programs, and hand-written reset/halt sequences.
module tb_alu_control_sequencer;

   localparam logic [15:0] M_PC_OUT  = 16'h8000;
   localparam logic [15:0] M_PC_INC  = 16'h4000;
   localparam logic [15:0] M_PC_LOAD = 16'h2000;
   localparam logic [15:0] M_MAR_IN  = 16'h1000;
   localparam logic [15:0] M_RAM_OUT = 16'h0800;
   localparam logic [15:0] M_RAM_IN  = 16'h0400;
   localparam logic [15:0] M_IR_IN   = 16'h0200;
   localparam logic [15:0] M_IR_OUT  = 16'h0100;
   localparam logic [15:0] M_A_IN    = 16'h0080;
   localparam logic [15:0] M_A_OUT   = 16'h0040;
   localparam logic [15:0] M_B_IN    = 16'h0020;
   localparam logic [15:0] M_ALU_OUT = 16'h0010;
   localparam logic [15:0] M_ALU_OP  = 16'h0008;
   localparam logic [15:0] M_ALU_WR  = 16'h0004;
   localparam logic [15:0] M_OUT_IN  = 16'h0002;
   localparam logic [15:0] M_HALTED  = 16'h0001;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic       carry = 1'b0;
   logic       zero = 1'b0;
   logic       pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
   logic       a_in, a_out, b_in, alu_out, alu_opcode, alu_wr, out_in, halted;
   logic [2:0] state;

   int n_cmp = 0;
   int n_fail = 0;

   alu_control_sequencer dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_opcode        (opcode),
      .i_carry_flag    (carry),
      .i_zero_flag     (zero),
      .o_pc_out        (pc_out),
      .o_pc_inc        (pc_inc),
      .o_pc_load       (pc_load),
      .o_mar_in        (mar_in),
      .o_ram_out       (ram_out),
      .o_ram_in        (ram_in),
      .o_ir_in         (ir_in),
      .o_ir_out        (ir_out),
      .o_a_in          (a_in),
      .o_a_out         (a_out),
      .o_b_in          (b_in),
      .o_alu_out       (alu_out),
      .o_alu_opcode    (alu_opcode),
      .o_alu_bus_wr_en (alu_wr),
      .o_out_in        (out_in),
      .o_halted        (halted),
      .o_state         (state)
   );

   always #5 clk = ~clk;

   wire [15:0] obs = {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
                      a_in, a_out, b_in, alu_out, alu_opcode, alu_wr, out_in, halted};

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %04h expected %04h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bus contention guard on every cycle.
   always @(negedge clk) begin
      check("bus_drivers", 16'(int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out) > 1), 16'd0);
   end

   // Reference model: expand one instruction into its expected per-cycle {state, word}.
   logic [2:0]  exp_state_q[$];
   logic [15:0] exp_word_q[$];

   task automatic push(input logic [2:0] s, input logic [15:0] w);
      exp_state_q.push_back(s);
      exp_word_q.push_back(w | M_ALU_OP);
   endtask

   task automatic model_instr(input logic [3:0] op, input logic c, input logic z);
      exp_state_q.delete();
      exp_word_q.delete();
      push(3'd0, M_PC_OUT | M_MAR_IN);
      push(3'd1, M_RAM_OUT | M_IR_IN | M_PC_INC);
      case (op)
         4'h1: begin push(3'd2, M_IR_OUT | M_MAR_IN); push(3'd3, M_RAM_OUT | M_A_IN); end
         4'h2, 4'h3: begin
            push(3'd2, M_IR_OUT | M_MAR_IN);
            push(3'd3, M_RAM_OUT | M_B_IN);
            exp_state_q.push_back(3'd4);
            exp_word_q.push_back(M_ALU_OUT | M_A_IN | M_ALU_WR | ((op == 4'h2) ? M_ALU_OP : 16'h0));
         end
         4'h4: begin push(3'd2, M_IR_OUT | M_MAR_IN); push(3'd3, M_A_OUT | M_RAM_IN); end
         4'h5: push(3'd2, M_IR_OUT | M_A_IN);
         4'h6: push(3'd2, M_IR_OUT | M_PC_LOAD);
         4'h7: push(3'd2, M_IR_OUT | (c ? M_PC_LOAD : 16'h0));
         4'h8: push(3'd2, M_IR_OUT | (z ? M_PC_LOAD : 16'h0));
         4'hE: push(3'd2, M_A_OUT | M_OUT_IN);
         4'hF: push(3'd5, M_HALTED);
         default: ;
      endcase
   endtask

   // Caller is 1 time unit past a rising edge with the sequencer in FETCH_ADDR.
   task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
      opcode = op;
      carry  = c;
      zero   = z;
      model_instr(op, c, z);
      while (exp_word_q.size() > 0) begin
         @(negedge clk);
         check($sformatf("state op%h", op), 16'(state), 16'(exp_state_q.pop_front()));
         check($sformatf("word op%h", op), obs, exp_word_q.pop_front());
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic        c;
      logic        z;
      int          len;
      logic [15:0] exec1;
   } vec_t;

   vec_t vecs[15];

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{4'h5, 1'b0, 1'b0, 3, M_IR_OUT | M_A_IN | M_ALU_OP};
      vecs[1]  = '{4'h2, 1'b0, 1'b0, 5, M_IR_OUT | M_MAR_IN | M_ALU_OP};
      vecs[2]  = '{4'h3, 1'b0, 1'b0, 5, M_IR_OUT | M_MAR_IN | M_ALU_OP};
      vecs[3]  = '{4'h1, 1'b0, 1'b0, 4, M_IR_OUT | M_MAR_IN | M_ALU_OP};
      vecs[4]  = '{4'h4, 1'b0, 1'b0, 4, M_IR_OUT | M_MAR_IN | M_ALU_OP};
      vecs[5]  = '{4'h6, 1'b0, 1'b0, 3, M_IR_OUT | M_PC_LOAD | M_ALU_OP};
      vecs[6]  = '{4'h7, 1'b0, 1'b1, 3, M_IR_OUT | M_ALU_OP};
      vecs[7]  = '{4'h7, 1'b1, 1'b0, 3, M_IR_OUT | M_PC_LOAD | M_ALU_OP};
      vecs[8]  = '{4'h8, 1'b1, 1'b0, 3, M_IR_OUT | M_ALU_OP};
      vecs[9]  = '{4'h8, 1'b0, 1'b1, 3, M_IR_OUT | M_PC_LOAD | M_ALU_OP};
      vecs[10] = '{4'hE, 1'b0, 1'b0, 3, M_A_OUT | M_OUT_IN | M_ALU_OP};
      vecs[11] = '{4'h0, 1'b0, 1'b0, 2, 16'h0};
      vecs[12] = '{4'h9, 1'b0, 1'b0, 2, 16'h0};
      vecs[13] = '{4'hC, 1'b1, 1'b1, 2, 16'h0};
      vecs[14] = '{4'hD, 1'b0, 1'b0, 2, 16'h0};

      // Reset held: idle word, state FETCH_ADDR.
      opcode = 4'h5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", 16'(state), 16'd0);
      check("reset_word", obs, M_ALU_OP);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // LDI straight out of reset: 0,1,2,0.
      run_instr(4'h5, 1'b0, 1'b0);
      run_instr(4'h2, 1'b0, 1'b0);
      run_instr(4'h3, 1'b1, 1'b1);

      foreach (vecs[i]) begin
         int cyc;
         opcode = vecs[i].op;
         carry  = vecs[i].c;
         zero   = vecs[i].z;
         cyc    = 0;
         do begin
            @(negedge clk);
            if (cyc == 2) check($sformatf("vec%0d_exec1", i), obs, vecs[i].exec1);
            @(posedge clk); #1;
            cyc++;
         end while (state != 3'd0 && cyc < 10);
         check($sformatf("vec%0d_len", i), 16'(cyc), 16'(vecs[i].len));
      end

      // Random program against the model.
      for (int n = 0; n < 200; n++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 14));
         run_instr(op, 1'($urandom), 1'($urandom));
      end

      // HLT: sticky halt with all strobes off.
      run_instr(4'hF, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         opcode = 4'($urandom);
         carry  = 1'($urandom);
         zero   = 1'($urandom);
         @(negedge clk);
         check("halt_state", 16'(state), 16'd5);
         check("halt_word", obs, M_HALTED | M_ALU_OP);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("halt_reset_state", 16'(state), 16'd0);
      check("halt_reset_word", obs, M_ALU_OP);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_instr(4'h5, 1'b0, 1'b0);

      // Reset during EXEC2 of ADD.
      opcode = 4'h2;
      carry  = 1'b0;
      zero   = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("add_exec2_state", 16'(state), 16'd3);
      check("add_exec2_word", obs, M_RAM_OUT | M_B_IN | M_ALU_OP);
      rst_n = 1'b0;
      #1;
      check("midreset_state", 16'(state), 16'd0);
      check("midreset_word", obs, M_ALU_OP);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_instr(4'h2, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
